// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and elaboration-time helpers for the truth-table sweeper.
package tts_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of input vectors in one sweep.
    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

    // Width of a packed truth table.
    function automatic int tbl_w(input int n_in, input int n_out);
        return n_out * num_vec(n_in);
    endfunction

    // Dwell counter width; never zero, so DWELL == 1 still yields a legal vector.
    function automatic int cnt_w(input int dwell);
        return (dwell > 1) ? clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Dwell counter: counts enabled cycles 0..DWELL-1 and flags the terminal count.
module dwell_timer
    import tts_pkg::*;
#(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = cnt_w(DWELL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick is high while the counter sits on its last value; with DWELL == 1 it is always high.
    assign tick_o = (cnt_q == LAST);

    // Next count: clear dominates, otherwise wrap to zero on the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus engine: walks every N_IN-bit vector, holds each for DWELL
// cycles, captures the DUT response into a packed table and scores it against
// an expected table.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int DWELL = 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [N_OUT-1:0]                 f_in,
    input  logic [N_OUT*(1<<N_IN)-1:0]       exp_table,
    output logic [N_IN-1:0]                  vec,
    output logic [N_OUT*(1<<N_IN)-1:0]       table_out,
    output logic                             busy,
    output logic                             done,
    output logic [N_IN:0]                    mismatch_cnt,
    output logic [N_IN-1:0]                  first_fail
);

    localparam int NUM_VEC = num_vec(N_IN);
    localparam int TBL_W   = tbl_w(N_IN, N_OUT);

    state_t             state_q;
    logic [N_IN-1:0]    vec_q;
    logic [TBL_W-1:0]   table_q;
    logic [N_IN:0]      mism_q;
    logic [N_IN-1:0]    first_fail_q;
    logic               busy_q;
    logic               done_q;

    logic               tick;
    logic [N_OUT-1:0]   exp_entry;
    logic               is_miss;

    // The timer only runs while vectors are being driven; it is held at zero otherwise.
    dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != DRIVE),
        .enable_i (state_q == DRIVE),
        .tick_o   (tick)
    );

    // Expected entry for the vector currently on the bus and its comparison with the DUT.
    always_comb begin
        exp_entry = exp_table[vec_q*N_OUT +: N_OUT];
        is_miss   = (f_in != exp_entry);
    end

    // Sweep controller: accept start, step vectors on each dwell tick, pulse done once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            table_q      <= '0;
            mism_q       <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Previous results stay visible until a new sweep is accepted.
                        state_q      <= DRIVE;
                        vec_q        <= '0;
                        table_q      <= '0;
                        mism_q       <= '0;
                        first_fail_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (tick) begin
                        table_q[vec_q*N_OUT +: N_OUT] <= f_in;
                        if (is_miss) begin
                            mism_q <= mism_q + 1'b1;
                            if (mism_q == '0) begin
                                first_fail_q <= vec_q;
                            end
                        end
                        if (&vec_q) begin
                            // Last vector sampled: vec stays at all-ones, no wrap.
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q <= vec_q + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec          = vec_q;
    assign table_out    = table_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = mism_q;
    assign first_fail   = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweeper instances (parity, AND with DWELL=1, two-output DUT).
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: N_IN=4, N_OUT=1, DWELL=20, parity DUT
    logic        start0 = 1'b0;
    logic [15:0] exp0 = 16'h6996;
    logic [3:0]  vec0;
    logic [15:0] table0;
    logic        busy0, done0;
    logic [4:0]  mism0;
    logic [3:0]  ff0;
    logic        f0;
    assign f0 = ^vec0;

    truth_table_sweeper #(.N_IN(4), .N_OUT(1), .DWELL(20)) u0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f0), .exp_table(exp0),
        .vec(vec0), .table_out(table0), .busy(busy0), .done(done0),
        .mismatch_cnt(mism0), .first_fail(ff0)
    );

    // Instance 1: N_IN=2, N_OUT=1, DWELL=1, AND DUT
    logic        start1 = 1'b0;
    logic [3:0]  exp1 = 4'h8;
    logic [1:0]  vec1;
    logic [3:0]  table1;
    logic        busy1, done1;
    logic [2:0]  mism1;
    logic [1:0]  ff1;
    logic        f1;
    assign f1 = &vec1;

    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f1), .exp_table(exp1),
        .vec(vec1), .table_out(table1), .busy(busy1), .done(done1),
        .mismatch_cnt(mism1), .first_fail(ff1)
    );

    // Instance 2: N_IN=3, N_OUT=2, DWELL=3, DUT = {a&b, a|c} with a = vec[2]
    // Entries 7..0: 11 11 01 01 01 00 01 00 -> 16'hF544
    logic        start2 = 1'b0;
    logic [15:0] exp2 = 16'hF544;
    logic [2:0]  vec2;
    logic [15:0] table2;
    logic        busy2, done2;
    logic [3:0]  mism2;
    logic [2:0]  ff2;
    logic [1:0]  f2;
    assign f2 = {vec2[2] & vec2[1], vec2[2] | vec2[0]};

    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(3)) u2 (
        .clk(clk), .rst(rst), .start(start2), .f_in(f2), .exp_table(exp2),
        .vec(vec2), .table_out(table2), .busy(busy2), .done(done2),
        .mismatch_cnt(mism2), .first_fail(ff2)
    );

    // Drive one sweep on u0; j counts falling edges after the acceptance edge.
    task automatic run_u0(input logic [15:0] exp_v, input int repulse_at,
                          output int done_at, output int done_cnt, output int vec_bad,
                          output logic busy_j0, output logic [15:0] tbl_j0,
                          output logic [4:0] mism_j0);
        exp0 = exp_v;
        done_at = -1;
        done_cnt = 0;
        vec_bad = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        busy_j0 = busy0;
        tbl_j0 = table0;
        mism_j0 = mism0;
        for (int j = 1; j <= 340; j++) begin
            @(negedge clk);
            start0 = (j == repulse_at);
            if (done0 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (j < 320 && (j % 20) == 10 && vec0 !== 4'(j / 20)) vec_bad++;
        end
        start0 = 1'b0;
        $display("sweep u0 exp=%h table=%h mism=%0d ff=%0d done_at=%0d",
                 exp_v, table0, mism0, ff0, done_at);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (vec0 !== 4'd0) begin n_bad++; $display("FAIL reset_vec0: got %0d want 0", vec0); end
        n_cmp++; if (table0 !== 16'h0) begin n_bad++; $display("FAIL reset_table0: got %h want 0", table0); end
        n_cmp++; if ({busy0, done0} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done0: got %b want 00", {busy0, done0}); end
        n_cmp++; if ({mism0, ff0} !== 9'd0) begin n_bad++; $display("FAIL reset_mism_ff0: got %h want 0", {mism0, ff0}); end
        n_cmp++; if ({vec1, table1, vec2, table2} !== 25'd0) begin n_bad++; $display("FAIL reset_u1_u2: got %h want 0", {vec1, table1, vec2, table2}); end
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_parity_match();
        int da, dc, vb; logic b0; logic [15:0] t0; logic [4:0] m0;
        run_u0(16'h6996, -1, da, dc, vb, b0, t0, m0);
        n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL parity_busy_after_accept: got %b want 1", b0); end
        n_cmp++; if (vb !== 0) begin n_bad++; $display("FAIL parity_vec_steps: got %0d bad want 0", vb); end
        n_cmp++; if (da !== 320) begin n_bad++; $display("FAIL parity_done_at: got %0d want 320", da); end
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL parity_done_count: got %0d want 1", dc); end
        n_cmp++; if (table0 !== 16'h6996) begin n_bad++; $display("FAIL parity_table: got %h want 6996", table0); end
        n_cmp++; if (mism0 !== 5'd0) begin n_bad++; $display("FAIL parity_mism: got %0d want 0", mism0); end
        n_cmp++; if ({busy0, vec0} !== 5'b0_1111) begin n_bad++; $display("FAIL parity_final_busy_vec: got %b want 01111", {busy0, vec0}); end
    endtask

    task automatic test_mismatch();
        int da, dc, vb; logic b0; logic [15:0] t0; logic [4:0] m0;
        run_u0(16'h6997, -1, da, dc, vb, b0, t0, m0);
        n_cmp++; if (mism0 !== 5'd1) begin n_bad++; $display("FAIL mism6997_cnt: got %0d want 1", mism0); end
        n_cmp++; if (ff0 !== 4'd0) begin n_bad++; $display("FAIL mism6997_first: got %0d want 0", ff0); end
        n_cmp++; if (table0 !== 16'h6996) begin n_bad++; $display("FAIL mism6997_table: got %h want 6996", table0); end
        run_u0(16'h2996, -1, da, dc, vb, b0, t0, m0);
        n_cmp++; if (m0 !== 5'd0) begin n_bad++; $display("FAIL mism2996_cleared: got %0d want 0", m0); end
        n_cmp++; if (mism0 !== 5'd1) begin n_bad++; $display("FAIL mism2996_cnt: got %0d want 1", mism0); end
        n_cmp++; if (ff0 !== 4'd14) begin n_bad++; $display("FAIL mism2996_first: got %0d want 14", ff0); end
        // Every entry wrong: count saturates the full range
        run_u0(16'h9669, -1, da, dc, vb, b0, t0, m0);
        n_cmp++; if (mism0 !== 5'd16) begin n_bad++; $display("FAIL mism_all_cnt: got %0d want 16", mism0); end
        n_cmp++; if (ff0 !== 4'd0) begin n_bad++; $display("FAIL mism_all_first: got %0d want 0", ff0); end
    endtask

    task automatic test_back_to_back();
        int da, dc, vb; logic b0; logic [15:0] t0; logic [4:0] m0;
        // Previous sweep left table=6996, mism=16; the new accept must clear both
        run_u0(16'h6996, 100, da, dc, vb, b0, t0, m0);
        n_cmp++; if (t0 !== 16'h0) begin n_bad++; $display("FAIL restart_table_cleared: got %h want 0", t0); end
        n_cmp++; if (m0 !== 5'd0) begin n_bad++; $display("FAIL restart_mism_cleared: got %0d want 0", m0); end
        n_cmp++; if (da !== 320) begin n_bad++; $display("FAIL restart_done_at: got %0d want 320", da); end
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", dc); end
        n_cmp++; if (vb !== 0) begin n_bad++; $display("FAIL restart_vec_steps: got %0d bad want 0", vb); end
        n_cmp++; if (table0 !== 16'h6996) begin n_bad++; $display("FAIL restart_table: got %h want 6996", table0); end
    endtask

    task automatic test_reset_mid_sweep();
        int da, dc, vb, stray; logic b0; logic [15:0] t0; logic [4:0] m0;
        exp0 = 16'h6996;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (150) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (vec0 !== 4'd0) begin n_bad++; $display("FAIL midrst_vec: got %0d want 0", vec0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy0); end
        n_cmp++; if (table0 !== 16'h0) begin n_bad++; $display("FAIL midrst_table: got %h want 0", table0); end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int j = 0; j < 340; j++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", stray); end
        $display("reset mid-sweep: vec=%0d busy=%b table=%h", vec0, busy0, table0);
        run_u0(16'h6996, -1, da, dc, vb, b0, t0, m0);
        n_cmp++; if (da !== 320) begin n_bad++; $display("FAIL midrst_resweep_done_at: got %0d want 320", da); end
        n_cmp++; if ({table0, mism0} !== {16'h6996, 5'd0}) begin n_bad++; $display("FAIL midrst_resweep_result: got %h want 6996_00", {table0, mism0}); end
    endtask

    task automatic test_dwell_one();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_cmp++; if ({busy1, vec1} !== 3'b1_00) begin n_bad++; $display("FAIL dwell1_accept: got %b want 100", {busy1, vec1}); end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            n_cmp++; if (vec1 !== 2'(j)) begin n_bad++; $display("FAIL dwell1_vec: got %0d want %0d", vec1, j); end
        end
        @(negedge clk);
        n_cmp++; if ({done1, busy1, vec1} !== 4'b10_11) begin n_bad++; $display("FAIL dwell1_done: got %b want 1011", {done1, busy1, vec1}); end
        n_cmp++; if ({table1, mism1} !== {4'h8, 3'd0}) begin n_bad++; $display("FAIL dwell1_result: got %h want 8_0", {table1, mism1}); end
        @(negedge clk);
        n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL dwell1_done_pulse: got %b want 0", done1); end
        $display("sweep u1 table=%h mism=%0d", table1, mism1);
    endtask

    task automatic run_u2(input logic [15:0] exp_v, output int done_at);
        exp2 = exp_v;
        done_at = -1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (done2 === 1'b1 && done_at < 0) done_at = j;
        end
        $display("sweep u2 exp=%h table=%h mism=%0d ff=%0d done_at=%0d",
                 exp_v, table2, mism2, ff2, done_at);
    endtask

    task automatic test_two_outputs();
        int da;
        run_u2(16'hF544, da);
        n_cmp++; if (da !== 24) begin n_bad++; $display("FAIL nout2_done_at: got %0d want 24", da); end
        n_cmp++; if (table2 !== 16'hF544) begin n_bad++; $display("FAIL nout2_table: got %h want F544", table2); end
        n_cmp++; if (mism2 !== 4'd0) begin n_bad++; $display("FAIL nout2_mism: got %0d want 0", mism2); end
        // Expected entry 7 altered to 01 while the DUT produces 11
        run_u2(16'h7544, da);
        n_cmp++; if ({mism2, ff2} !== {4'd1, 3'd7}) begin n_bad++; $display("FAIL nout2_last_fail: got %h want 1_7", {mism2, ff2}); end
    endtask

    initial begin
        test_reset();
        test_parity_match();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_sweep();
        test_dwell_one();
        test_two_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
